// File: rtl/dut_frame_relay.sv
// -----------------------------------------------------------------------------
// dut_frame_relay
//   Serial store-and-forward frame relay. Bits arriving on rxd while rx_dv is
//   high are packed LSB first into bytes and stored in a byte FIFO. A length
//   FIFO records each completed frame. The TX engine replays every committed
//   frame on txd/tx_en, keeping at least IFG idle cycles between frames.
//
//   Optional build macro: TX_PARITY_EN
//     When defined, an even-parity bit (XOR of the 8 data bits) follows every
//     transmitted byte with tx_en held high.
// -----------------------------------------------------------------------------
module dut_frame_relay #(
    parameter int DATA_DEPTH = 64,
    parameter int LEN_DEPTH  = 4,
    parameter int IFG        = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic rxd,
    input  logic rx_dv,
    output logic txd,
    output logic tx_en
);

    localparam int AW = $clog2(DATA_DEPTH);
    localparam int LW = $clog2(LEN_DEPTH);
    localparam int CW = AW + 1;              // holds a byte count of 0..DATA_DEPTH
    localparam int GW = $clog2(IFG + 1);

`ifdef TX_PARITY_EN
    localparam logic [3:0] LAST_BIT = 4'd8;  // bit slot 8 carries the parity bit
`else
    localparam logic [3:0] LAST_BIT = 4'd7;
`endif

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_LOAD = 2'd1;
    localparam logic [1:0] S_SEND = 2'd2;
    localparam logic [1:0] S_GAP  = 2'd3;

    // Storage
    logic [7:0]    data_mem [DATA_DEPTH];
    logic [CW-1:0] len_mem  [LEN_DEPTH];

    // Pointers carry one extra wrap bit to tell full from empty
    logic [AW:0]   wr_ptr, rd_ptr, frm_start;
    logic [LW:0]   len_wr, len_rd;

    // RX state
    logic [6:0]    rx_sr;      // bits already received of the current byte
    logic [2:0]    rx_bits;
    logic [CW-1:0] rx_cnt;
    logic          rx_active;  // rx_dv was high on the previous edge
    logic          rx_drop;    // current frame is being discarded

    // TX state
    logic [1:0]    state;
    logic [7:0]    tx_byte;
    logic [3:0]    tx_bit;
    logic [CW-1:0] tx_left;
    logic [GW-1:0] gap_cnt;

    // Derived status and datapath
    logic          data_full, len_full, len_empty;
    logic [7:0]    rx_byte;
    logic          data_we, len_we;
    logic [7:0]    rd_byte;
    logic [2:0]    nb_idx;
    logic          next_bit;

    // Status flags, write strobes and the next TX bit
    always_comb begin
        // NOTE: every signal driven here gets a value on every path, so no latch is inferred.
        data_full = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
        len_full  = (len_wr[LW] != len_rd[LW]) && (len_wr[LW-1:0] == len_rd[LW-1:0]);
        len_empty = (len_wr == len_rd);
        rx_byte   = {rxd, rx_sr};
        data_we   = rx_dv && !rx_drop && (rx_bits == 3'd7) && !data_full;
        len_we    = !rx_dv && rx_active && !rx_drop && (rx_cnt != '0) && !len_full;
        rd_byte   = data_mem[rd_ptr[AW-1:0]];
        nb_idx    = tx_bit[2:0] + 3'd1;
        next_bit  = (tx_bit == 4'd7) ? ^tx_byte : tx_byte[nb_idx];
    end

    // FIFO payload storage; contents are only meaningful between the pointers
    // NOTE: the memories are deliberately not reset; the pointers alone define what is valid.
    always_ff @(posedge clk) begin
        if (data_we) data_mem[wr_ptr[AW-1:0]] <= rx_byte;
        if (len_we)  len_mem[len_wr[LW-1:0]]  <= rx_cnt;
    end

    // RX: bit packing, frame byte count, commit or rollback at frame end
    always_ff @(posedge clk or negedge rst_n) begin
        // NOTE: state registers use non-blocking assignments so every read sees the pre-edge value.
        if (!rst_n) begin
            rx_sr     <= '0;
            rx_bits   <= '0;
            rx_cnt    <= '0;
            rx_active <= 1'b0;
            rx_drop   <= 1'b0;
            wr_ptr    <= '0;
            frm_start <= '0;
            len_wr    <= '0;
        end else begin
            rx_active <= rx_dv;
            if (rx_dv) begin
                if (!rx_drop) begin
                    rx_sr   <= rx_byte[7:1];
                    rx_bits <= rx_bits + 3'd1;
                    if (rx_bits == 3'd7) begin
                        if (data_full) begin
                            // No room: discard everything written for this frame
                            wr_ptr  <= frm_start;
                            rx_drop <= 1'b1;
                        end else begin
                            wr_ptr <= wr_ptr + (AW+1)'(1);
                            rx_cnt <= rx_cnt + CW'(1);
                        end
                    end
                end
            end else if (rx_active) begin
                // Frame end: partial bits are simply forgotten
                if (!rx_drop && (rx_cnt != '0)) begin
                    if (len_full) begin
                        wr_ptr <= frm_start;
                    end else begin
                        frm_start <= wr_ptr;
                        len_wr    <= len_wr + (LW+1)'(1);
                    end
                end
                rx_drop <= 1'b0;
                rx_bits <= '0;
                rx_cnt  <= '0;
            end
        end
    end

    // TX: IDLE -> LOAD -> SEND -> GAP sequencer driving registered txd/tx_en
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= S_IDLE;
            txd     <= 1'b0;
            tx_en   <= 1'b0;
            rd_ptr  <= '0;
            len_rd  <= '0;
            tx_byte <= '0;
            tx_bit  <= '0;
            tx_left <= '0;
            gap_cnt <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (!len_empty) state <= S_LOAD;
                end
                S_LOAD: begin
                    tx_left <= len_mem[len_rd[LW-1:0]];
                    len_rd  <= len_rd + (LW+1)'(1);
                    tx_byte <= rd_byte;
                    rd_ptr  <= rd_ptr + (AW+1)'(1);
                    tx_bit  <= '0;
                    txd     <= rd_byte[0];
                    tx_en   <= 1'b1;
                    state   <= S_SEND;
                end
                S_SEND: begin
                    if (tx_bit != LAST_BIT) begin
                        tx_bit <= tx_bit + 4'd1;
                        txd    <= next_bit;
                    end else if (tx_left != CW'(1)) begin
                        // Next byte of the same frame follows with no gap
                        tx_left <= tx_left - CW'(1);
                        tx_byte <= rd_byte;
                        rd_ptr  <= rd_ptr + (AW+1)'(1);
                        tx_bit  <= '0;
                        txd     <= rd_byte[0];
                    end else begin
                        txd     <= 1'b0;
                        tx_en   <= 1'b0;
                        gap_cnt <= GW'(IFG - 1);
                        state   <= S_GAP;
                    end
                end
                S_GAP: begin
                    if (gap_cnt == '0) state <= S_IDLE;
                    else               gap_cnt <= gap_cnt - GW'(1);
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_dut_frame_relay.sv
// -----------------------------------------------------------------------------
// tb_dut_frame_relay
//   Directed bench for dut_frame_relay. Expected TX bits are queued as each
//   frame is driven and compared bit by bit as tx_en delivers them.
//   Honours TX_PARITY_EN to match the DUT build.
// -----------------------------------------------------------------------------
module tb_dut_frame_relay;

    localparam int IFG = 2;
`ifdef TX_PARITY_EN
    localparam int BPB = 9;
`else
    localparam int BPB = 8;
`endif

    logic clk = 1'b0;
    logic rst_n;
    logic rxd;
    logic rx_dv;
    logic txd;
    logic tx_en;

    dut_frame_relay #(
        .DATA_DEPTH(64),
        .LEN_DEPTH (4),
        .IFG       (IFG)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .rxd  (rxd),
        .rx_dv(rx_dv),
        .txd  (txd),
        .tx_en(tx_en)
    );

    always #5 clk = ~clk;

    int   tests = 0;
    int   fails = 0;
    int   cyc = 0;
    logic exp_q[$];

    // Monitor state
    bit mon_en = 1'b1;
    int frames = 0;
    int rise_cyc = -1;
    int fall_cyc = 0;
    bit have_fall = 1'b0;
    int run_len = 0;
    int last_len = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
        tests++;
        assert (got === want)
        else begin
            fails++;
            $error("FAIL %s: got 0x%0h expected 0x%0h", tag, got, want);
        end
    endtask

    // Queue the expected TX bits of one byte
    task automatic push_byte(input logic [7:0] b);
        for (int i = 0; i < 8; i++) exp_q.push_back(b[i]);
`ifdef TX_PARITY_EN
        exp_q.push_back(^b);
`endif
    endtask

    // Drive n bits of b, LSB first, with rx_dv high
    task automatic send_bits(input logic [7:0] b, input int n);
        for (int i = 0; i < n; i++) begin
            rx_dv = 1'b1;
            rxd   = b[i];
            @(posedge clk);
            #1;
        end
    endtask

    task automatic end_frame(input int idle);
        rx_dv = 1'b0;
        rxd   = 1'b0;
        repeat (idle) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Wait until every queued bit has been seen and TX is quiet, bounded
    task automatic wait_drain(input string tag, input int budget);
        int n = 0;
        while ((exp_q.size() != 0 || tx_en) && n < budget) begin
            @(posedge clk);
            #1;
            n++;
        end
        check({"drain_", tag}, 32'(n < budget), 32'd1);
        repeat (20) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Cycle counter: value after edge k is k
    initial forever begin
        @(posedge clk);
        cyc++;
    end

    // Output monitor on the falling edge
    initial forever begin
        logic prev_en = 1'b0;
        logic e;
        @(negedge clk);
        if (tx_en) begin
            if (!prev_en) begin
                frames++;
                rise_cyc = cyc;
                run_len = 0;
                if (have_fall) check("ifg", 32'((cyc - fall_cyc) >= IFG), 32'd1);
            end
            run_len++;
            if (mon_en) begin
                check("tx_bit_expected", 32'(exp_q.size() != 0), 32'd1);
                if (exp_q.size() != 0) begin
                    e = exp_q.pop_front();
                    check("txd_bit", 32'(txd), 32'(e));
                end
            end
        end else begin
            if (prev_en) begin
                last_len = run_len;
                fall_cyc = cyc;
                have_fall = 1'b1;
            end
            check("txd_idle_zero", 32'(txd), 32'd0);
        end
        prev_en = tx_en;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, tests=%0d failed=%0d", tests, fails);
        $fatal(1, "watchdog");
    end

    initial begin
        int t0;
        int f0;
        int n;

        rst_n = 1'b0;
        rx_dv = 1'b0;
        rxd   = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("reset_txd", 32'(txd), 32'd0);
        check("reset_tx_en", 32'(tx_en), 32'd0);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // 1: single byte 0xA5, latency T0+2, 8 (or 9) cycles
        f0 = frames;
        send_bits(8'hA5, 8);
        push_byte(8'hA5);
        rx_dv = 1'b0;
        rxd   = 1'b0;
        @(posedge clk);
        #1;
        t0 = cyc;
        wait_drain("a5", 200);
        check("a5_latency", 32'(rise_cyc), 32'(t0 + 2));
        check("a5_len", 32'(last_len), 32'(BPB));
        check("a5_frames", 32'(frames - f0), 32'd1);

        // 2: back-to-back frames 0x3C then 0xFF,0x01
        f0 = frames;
        send_bits(8'h3C, 8);
        push_byte(8'h3C);
        end_frame(1);
        send_bits(8'hFF, 8);
        push_byte(8'hFF);
        send_bits(8'h01, 8);
        push_byte(8'h01);
        end_frame(1);
        wait_drain("b2b", 300);
        check("b2b_frames", 32'(frames - f0), 32'd2);
        check("b2b_len", 32'(last_len), 32'(2 * BPB));

        // 3: trailing partial bits dropped; sub-byte frame ignored
        f0 = frames;
        send_bits(8'h5A, 8);
        send_bits(8'h0D, 4);
        push_byte(8'h5A);
        end_frame(1);
        send_bits(8'h1F, 5);
        end_frame(1);
        wait_drain("partial", 200);
        check("partial_frames", 32'(frames - f0), 32'd1);
        check("partial_len", 32'(last_len), 32'(BPB));

        // 4: 65-byte frame overflows the data FIFO and is dropped
        f0 = frames;
        for (int i = 0; i < 65; i++) send_bits(8'(i * 3 + 1), 8);
        end_frame(1);
        send_bits(8'h81, 8);
        push_byte(8'h81);
        end_frame(1);
        wait_drain("overflow", 300);
        check("overflow_frames", 32'(frames - f0), 32'd1);
        check("overflow_len", 32'(last_len), 32'(BPB));

        // 5: TX busy with a long frame while 5 short frames arrive; 5th dropped
        f0 = frames;
        for (int i = 0; i < 20; i++) begin
            send_bits(8'(8'hC0 ^ i), 8);
            push_byte(8'(8'hC0 ^ i));
        end
        end_frame(1);
        for (int i = 1; i <= 5; i++) begin
            send_bits(8'(i * 8'h11), 8);
            if (i <= 4) push_byte(8'(i * 8'h11));
            end_frame(1);
        end
        wait_drain("lenfull", 2000);
        check("lenfull_frames", 32'(frames - f0), 32'd5);
        check("lenfull_len", 32'(last_len), 32'(BPB));

        // 6: reset pulsed mid-transmission clears outputs at once
        mon_en = 1'b0;
        send_bits(8'hC3, 8);
        send_bits(8'h3C, 8);
        end_frame(1);
        n = 0;
        while (!tx_en && n < 20) begin
            @(posedge clk);
            #1;
            n++;
        end
        check("rst_tx_started", 32'(tx_en), 32'd1);
        repeat (3) @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check("rst_async_txd", 32'(txd), 32'd0);
        check("rst_async_tx_en", 32'(tx_en), 32'd0);
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        f0 = frames;
        repeat (40) begin
            @(posedge clk);
            #1;
        end
        check("rst_no_resume", 32'(frames - f0), 32'd0);
        mon_en = 1'b1;

        // 7: byte 0x07 (parity bit 1 when parity is built in)
        f0 = frames;
        send_bits(8'h07, 8);
        push_byte(8'h07);
        end_frame(1);
        wait_drain("b07", 200);
        check("b07_frames", 32'(frames - f0), 32'd1);
        check("b07_len", 32'(last_len), 32'(BPB));

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
